// File: rtl/osc_phase_mixer.sv
// osc_phase_mixer: per-oscillator fixed-point phase accumulators feeding the
// wave_loader index ports once per audio sample tick, followed by a serial
// signed sum of the gated oscillator samples, a scale-down shift and saturation.
//
// Handshake: sample_tick_in is accepted only when busy_out is low; a tick seen
// while busy is discarded and reported one cycle later on tick_drop_out.
// mix_valid_out is high for exactly one cycle, during which mix_out already
// carries the new sample; mix_out then holds until the next completed frame.
module osc_phase_mixer #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int WW_WIDTH        = 18,
    parameter int FRAC_WIDTH      = 8,
    parameter int BRAM_LATENCY    = 2,
    parameter int MIX_SHIFT       = 2
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             sample_tick_in,
    input  logic [WW_WIDTH-1:0]                              wave_width_in,
    input  logic                                             ui_update_trig_in,
    input  logic [NUM_OSCILLATORS-1:0]                       osc_is_on_in,
    input  logic [NUM_OSCILLATORS*(WW_WIDTH+FRAC_WIDTH)-1:0] osc_phase_inc_in,
    output logic [NUM_OSCILLATORS*WW_WIDTH-1:0]              osc_index_out,
    input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0]          osc_data_in,
    output logic [SAMPLE_WIDTH-1:0]                          mix_out,
    output logic                                             mix_valid_out,
    output logic                                             busy_out,
    output logic                                             tick_drop_out
);

    localparam int PHASE_WIDTH = WW_WIDTH + FRAC_WIDTH;
    localparam int ACC_WIDTH   = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS);
    localparam int CNT_MAX     = (BRAM_LATENCY > NUM_OSCILLATORS) ? BRAM_LATENCY : NUM_OSCILLATORS;
    localparam int CNT_WIDTH   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(BRAM_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_OSC  = CNT_WIDTH'(NUM_OSCILLATORS - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (SAMPLE_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [CNT_WIDTH-1:0]          cnt;
    logic                          start_frame;

    logic [PHASE_WIDTH-1:0]        phase_acc  [NUM_OSCILLATORS];
    logic [PHASE_WIDTH-1:0]        phase_next [NUM_OSCILLATORS];
    logic [PHASE_WIDTH:0]          wave_len;
    logic [PHASE_WIDTH:0]          step_sum;
    logic [PHASE_WIDTH-1:0]        step_inc;
    logic                          narrow_wave;

    logic [SAMPLE_WIDTH-1:0]       cur_sample;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_term;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_shift;
    logic signed [ACC_WIDTH-1:0]   mix_sat;

    // A tick is accepted only from IDLE and never alongside a wave reload.
    assign start_frame = (state == S_IDLE) && sample_tick_in && !ui_update_trig_in;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a wave reload aborts any frame back to IDLE.
    always_comb begin
        state_next = state;
        if (ui_update_trig_in) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (sample_tick_in) state_next = S_WAIT;
                S_WAIT:  if (cnt == LAST_WAIT) state_next = S_ACCUM;
                S_ACCUM: if (cnt == LAST_OSC) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy_out      = (state != S_IDLE);
        mix_valid_out = (state == S_DONE);
    end

    // Shared cycle counter for the BRAM wait and the oscillator walk; restarts on every state change.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if ((state == S_WAIT) || (state == S_ACCUM)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // Candidate phases for the next tick: one-bit-wider add, a single wrap, then
    // clear anything still out of range (increment larger than the wave).
    always_comb begin
        wave_len    = {1'b0, wave_width_in, {FRAC_WIDTH{1'b0}}};
        narrow_wave = (wave_width_in <= WW_WIDTH'(1));
        step_sum    = '0;
        step_inc    = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            step_inc = osc_phase_inc_in[i*PHASE_WIDTH +: PHASE_WIDTH];
            step_sum = {1'b0, phase_acc[i]} + {1'b0, step_inc};
            if (step_sum >= wave_len) begin
                step_sum = step_sum - wave_len;
            end
            if (!osc_is_on_in[i] || narrow_wave || (step_sum >= wave_len)) begin
                phase_next[i] = '0;
            end else begin
                phase_next[i] = step_sum[PHASE_WIDTH-1:0];
            end
        end
    end

    // Phase registers: cleared by reset or wave reload, advanced only on an accepted tick.
    always_ff @(posedge clk_in) begin
        if (rst_in || ui_update_trig_in) begin
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                phase_acc[i] <= '0;
            end
        end else if (start_frame) begin
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                phase_acc[i] <= phase_next[i];
            end
        end
    end

    // Wave indices are the integer part of each phase, so they hold between ticks.
    always_comb begin
        osc_index_out = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            osc_index_out[i*WW_WIDTH +: WW_WIDTH] = phase_acc[i][PHASE_WIDTH-1:FRAC_WIDTH];
        end
    end

    // Select the sample of the oscillator being summed (zero when gated off), then scale and clamp.
    always_comb begin
        cur_sample = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if ((cnt == CNT_WIDTH'(i)) && osc_is_on_in[i]) begin
                cur_sample = osc_data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        acc_term  = {{(ACC_WIDTH-SAMPLE_WIDTH){cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};
        acc_sum   = acc + acc_term;
        acc_shift = acc_sum >>> MIX_SHIFT;
        if (acc_shift > SAT_MAX) begin
            mix_sat = SAT_MAX;
        end else if (acc_shift < SAT_MIN) begin
            mix_sat = SAT_MIN;
        end else begin
            mix_sat = acc_shift;
        end
    end

    // Accumulator, mix register and drop flag; mix_out is loaded on the last
    // summing edge so it is already valid during the DONE cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc           <= '0;
            mix_out       <= '0;
            tick_drop_out <= 1'b0;
        end else begin
            tick_drop_out <= sample_tick_in && !ui_update_trig_in && (state != S_IDLE);
            if (start_frame) begin
                acc <= '0;
            end else if ((state == S_ACCUM) && !ui_update_trig_in) begin
                acc <= acc_sum;
                if (cnt == LAST_OSC) begin
                    mix_out <= mix_sat[SAMPLE_WIDTH-1:0];
                end
            end
        end
    end

endmodule
